ll_fwb_arbiter: RTL and testbench

Round-robin arbiter that shares the single long-latency FP register-file write port between `NUM_REQ` producers. Producers are the integer-to-FP response queue of each ALU execution unit and the FP divide/sqrt unit. It sits between those producers' branch-killable queues and the FP register file / ROB writeback. It grants one requester per cycle and registers the winning response in a one-entry writeback stage. Both the requests and the held response are subject to branch-mask resolution, mispredict kill and pipeline flush.

---
 rtl/ll_fwb_arbiter_pkg.sv | 25 ++
 rtl/ll_fwb_arbiter_rr_grant_picker.sv | 32 +++
 rtl/ll_fwb_arbiter.sv | 124 ++++++++++++
 tb/tb_ll_fwb_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ll_fwb_arbiter_pkg.sv
// Shared constants and the writeback payload layout for the long-latency FP
// writeback arbiter.
package ll_fwb_arbiter_pkg;

  localparam int BR_W      = 20;
  localparam int DATA_W    = 65;
  localparam int ROB_IDX_W = 7;
  localparam int PREG_W    = 7;

  // Destination register type encodings carried in dst_rtype.
  localparam logic [1:0] RT_FLT = 2'd1;
  localparam logic [1:0] RT_X   = 2'd2;

  // Payload carried from a requester into the writeback stage.
  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    pdst;
    logic [1:0]           dst_rtype;
    logic [BR_W-1:0]      br_mask;
    logic [DATA_W-1:0]    data;
    logic                 fflags_valid;
    logic [4:0]           fflags;
  } fwb_resp_t;

endpackage

// File: rtl/ll_fwb_arbiter_rr_grant_picker.sv
// Combinational round-robin picker: first eligible requester at or after
// rr_ptr, wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_grant_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [PTR_W-1:0] idx;

  // Scan from rr_ptr and take the first eligible requester found.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_valid && eligible[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/ll_fwb_arbiter.sv
// Round-robin arbiter for the shared long-latency FP register-file write port.
// One grant per cycle; the winner is registered in a one-entry writeback stage
// that keeps tracking branch resolution and is killed by mispredict or flush.
//
// Handshake: a requester dequeues exactly when io_req_valid[i] & io_req_ready[i];
// ready is the grant itself and is never raised for an ineligible request.
// The writeback port has no ready: io_wb_valid is a one-cycle pulse.
module ll_fwb_arbiter
  import ll_fwb_arbiter_pkg::ROB_IDX_W;
  import ll_fwb_arbiter_pkg::PREG_W;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 65,
  parameter int BR_W    = 20
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                io_req_valid,
  output logic [NUM_REQ-1:0]                io_req_ready,
  input  logic [NUM_REQ-1:0][BR_W-1:0]      io_req_bits_uop_br_mask,
  input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] io_req_bits_uop_rob_idx,
  input  logic [NUM_REQ-1:0][PREG_W-1:0]    io_req_bits_uop_pdst,
  input  logic [NUM_REQ-1:0][1:0]           io_req_bits_uop_dst_rtype,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    io_req_bits_data,
  input  logic [NUM_REQ-1:0]                io_req_bits_fflags_valid,
  input  logic [NUM_REQ-1:0][4:0]           io_req_bits_fflags_bits_flags,
  input  logic [BR_W-1:0]                   io_brupdate_b1_resolve_mask,
  input  logic [BR_W-1:0]                   io_brupdate_b1_mispredict_mask,
  input  logic                              io_flush,
  output logic                              io_wb_valid,
  output logic [ROB_IDX_W-1:0]              io_wb_bits_uop_rob_idx,
  output logic [PREG_W-1:0]                 io_wb_bits_uop_pdst,
  output logic [1:0]                        io_wb_bits_uop_dst_rtype,
  output logic [BR_W-1:0]                   io_wb_bits_uop_br_mask,
  output logic [DATA_W-1:0]                 io_wb_bits_data,
  output logic                              io_wb_bits_fflags_valid,
  output logic [4:0]                        io_wb_bits_fflags_bits_flags,
  output logic                              io_conflict
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   rr_ptr;

  logic                 r_valid;
  logic [ROB_IDX_W-1:0] r_rob_idx;
  logic [PREG_W-1:0]    r_pdst;
  logic [1:0]           r_dst_rtype;
  logic [BR_W-1:0]      r_br_mask;
  logic [DATA_W-1:0]    r_data;
  logic                 r_fflags_valid;
  logic [4:0]           r_fflags;

  // A request competes only if it is not being killed this very cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = io_req_valid[i]
                  & ~|(io_req_bits_uop_br_mask[i] & io_brupdate_b1_mispredict_mask)
                  & ~io_flush & ~reset;
    end
  end

  rr_grant_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign io_req_ready = grant;
  assign io_conflict  = ($countones(eligible) >= 2);

  // Pointer advance and writeback-stage capture; the held mask keeps resolving.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr         <= '0;
      r_valid        <= 1'b0;
      r_rob_idx      <= '0;
      r_pdst         <= '0;
      r_dst_rtype    <= '0;
      r_br_mask      <= '0;
      r_data         <= '0;
      r_fflags_valid <= 1'b0;
      r_fflags       <= '0;
    end else begin
      r_valid <= grant_valid;
      if (grant_valid) begin
        rr_ptr         <= PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
        r_rob_idx      <= io_req_bits_uop_rob_idx[grant_idx];
        r_pdst         <= io_req_bits_uop_pdst[grant_idx];
        r_dst_rtype    <= io_req_bits_uop_dst_rtype[grant_idx];
        r_br_mask      <= io_req_bits_uop_br_mask[grant_idx] & ~io_brupdate_b1_resolve_mask;
        r_data         <= io_req_bits_data[grant_idx];
        r_fflags_valid <= io_req_bits_fflags_valid[grant_idx];
        r_fflags       <= io_req_bits_fflags_bits_flags[grant_idx];
      end else begin
        r_br_mask <= r_br_mask & ~io_brupdate_b1_resolve_mask;
      end
    end
  end

  // Kill uses the held (pre-resolve) mask; reset drops the entry immediately.
  assign io_wb_valid = r_valid
                     & ~|(r_br_mask & io_brupdate_b1_mispredict_mask)
                     & ~io_flush & ~reset;

  assign io_wb_bits_uop_rob_idx       = r_rob_idx;
  assign io_wb_bits_uop_pdst          = r_pdst;
  assign io_wb_bits_uop_dst_rtype     = r_dst_rtype;
  assign io_wb_bits_uop_br_mask       = r_br_mask;
  assign io_wb_bits_data              = r_data;
  assign io_wb_bits_fflags_valid      = r_fflags_valid;
  assign io_wb_bits_fflags_bits_flags = r_fflags;

endmodule

// File: tb/tb_ll_fwb_arbiter.sv
// Bench for ll_fwb_arbiter: directed scenarios drive two requesters, predict
// grants from a round-robin order known to the bench, and queue the expected
// writeback payload; a negedge monitor pops and compares every writeback.
module tb_ll_fwb_arbiter;
  import ll_fwb_arbiter_pkg::*;

  localparam int N = 2;

  logic              clock;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0][19:0] bm;
  logic [N-1:0][6:0] rob;
  logic [N-1:0][6:0] pdst;
  logic [N-1:0][1:0] rtype;
  logic [N-1:0][64:0] data;
  logic [N-1:0]      ffv;
  logic [N-1:0][4:0] ffl;
  logic [19:0]       resolve;
  logic [19:0]       mispred;
  logic              flush;
  logic              wb_valid;
  logic [6:0]        wb_rob;
  logic [6:0]        wb_pdst;
  logic [1:0]        wb_rtype;
  logic [19:0]       wb_bm;
  logic [64:0]       wb_data;
  logic              wb_ffv;
  logic [4:0]        wb_ffl;
  logic              conflict;

  fwb_resp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  ll_fwb_arbiter #(.NUM_REQ(N), .DATA_W(65), .BR_W(20)) dut (
    .clock                          (clock),
    .reset                          (reset),
    .io_req_valid                   (req_valid),
    .io_req_ready                   (req_ready),
    .io_req_bits_uop_br_mask        (bm),
    .io_req_bits_uop_rob_idx        (rob),
    .io_req_bits_uop_pdst           (pdst),
    .io_req_bits_uop_dst_rtype      (rtype),
    .io_req_bits_data               (data),
    .io_req_bits_fflags_valid       (ffv),
    .io_req_bits_fflags_bits_flags  (ffl),
    .io_brupdate_b1_resolve_mask    (resolve),
    .io_brupdate_b1_mispredict_mask (mispred),
    .io_flush                       (flush),
    .io_wb_valid                    (wb_valid),
    .io_wb_bits_uop_rob_idx         (wb_rob),
    .io_wb_bits_uop_pdst            (wb_pdst),
    .io_wb_bits_uop_dst_rtype       (wb_rtype),
    .io_wb_bits_uop_br_mask         (wb_bm),
    .io_wb_bits_data                (wb_data),
    .io_wb_bits_fflags_valid        (wb_ffv),
    .io_wb_bits_fflags_bits_flags   (wb_ffl),
    .io_conflict                    (conflict)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every writeback must match the oldest expected entry.
  always @(negedge clock) begin
    fwb_resp_t got;
    fwb_resp_t e;
    if (wb_valid === 1'b1) begin
      got = '{rob_idx: wb_rob, pdst: wb_pdst, dst_rtype: wb_rtype, br_mask: wb_bm,
              data: wb_data, fflags_valid: wb_ffv, fflags: wb_ffl};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got %h, required no writeback", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL wb_payload: got %h, required %h", got, e);
        end
      end
    end
  end

  // Driver helpers.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_req(input int i, input logic [19:0] m);
    req_valid[i] = 1'b1;
    bm[i]        = m;
    rob[i]       = 7'($urandom_range(0, 127));
    pdst[i]      = 7'($urandom_range(0, 127));
    rtype[i]     = ($urandom_range(0, 1) == 0) ? RT_FLT : RT_X;
    data[i]      = {1'($urandom_range(0, 1)), $urandom(), $urandom()};
    ffv[i]       = 1'($urandom_range(0, 1));
    ffl[i]       = 5'($urandom_range(0, 31));
  endtask

  task automatic idle();
    req_valid = '0;
    resolve   = '0;
    mispred   = '0;
    flush     = 1'b0;
  endtask

  function automatic fwb_resp_t make_exp(input int i, input logic [19:0] res);
    fwb_resp_t e;
    e.rob_idx      = rob[i];
    e.pdst         = pdst[i];
    e.dst_rtype    = rtype[i];
    e.br_mask      = bm[i] & ~res;
    e.data         = data[i];
    e.fflags_valid = ffv[i];
    e.fflags       = ffl[i];
    return e;
  endfunction

  task automatic chk_ready(input string name, input logic [N-1:0] expv);
    checks++;
    if (req_ready !== expv) begin
      errors++;
      $display("FAIL %s: ready=%b required %b", name, req_ready, expv);
    end
  endtask

  // Tests.
  task automatic test_reset();
    reset = 1'b1;
    idle();
    set_req(0, 20'h0);
    set_req(1, 20'h0);
    step();
    settle();
    chk_ready("reset_ready", 2'b00);
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wb_valid: got %b required 0", wb_valid);
    end
    step();
    reset = 1'b0;
    idle();
    settle();
    checks++;
    if (wb_valid !== 1'b0 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: wb_valid=%b conflict=%b required 0 0", wb_valid, conflict);
    end
    step();
  endtask

  task automatic test_alternate();
    for (int c = 0; c < 6; c++) begin
      set_req(0, 20'h0);
      set_req(1, 20'h0);
      settle();
      chk_ready("alt_grant", (c % 2 == 0) ? 2'b01 : 2'b10);
      checks++;
      if (conflict !== 1'b1) begin
        errors++;
        $display("FAIL alt_conflict: got %b required 1", conflict);
      end
      if (c > 0) begin
        checks++;
        if (wb_valid !== 1'b1) begin
          errors++;
          $display("FAIL alt_wb_valid: cycle %0d got %b required 1", c, wb_valid);
        end
      end
      exp_q.push_back(make_exp(c % 2, 20'h0));
      step();
    end
    idle();
    step();
  endtask

  task automatic test_mispredict();
    set_req(0, 20'h00004);
    set_req(1, 20'h0);
    mispred = 20'h00004;
    settle();
    chk_ready("mispred_grant", 2'b10);
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL mispred_conflict: got %b required 0", conflict);
    end
    exp_q.push_back(make_exp(1, 20'h0));
    step();
    mispred = '0;
    set_req(0, 20'h0);
    set_req(1, 20'h0);
    settle();
    chk_ready("mispred_ptr_next", 2'b01);
    exp_q.push_back(make_exp(0, 20'h0));
    step();
    idle();
    step();
  endtask

  task automatic test_resolve_kill();
    set_req(1, 20'h00018);
    settle();
    chk_ready("kill_grant", 2'b10);
    step();
    idle();
    resolve = 20'h00008;
    mispred = 20'h00010;
    settle();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_wb_valid: got %b required 0", wb_valid);
    end
    step();
    idle();
    settle();
    checks++;
    if (wb_bm !== 20'h00010 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_held_mask: mask=%h valid=%b required 00010 0", wb_bm, wb_valid);
    end
    step();
  endtask

  task automatic test_resolve_on_grant();
    set_req(0, 20'h00003);
    resolve = 20'h00001;
    settle();
    chk_ready("resgrant_grant", 2'b01);
    exp_q.push_back(make_exp(0, 20'h00001));
    step();
    idle();
    settle();
    checks++;
    if (wb_valid !== 1'b1 || wb_bm !== 20'h00002) begin
      errors++;
      $display("FAIL resgrant_held: valid=%b mask=%h required 1 00002", wb_valid, wb_bm);
    end
    step();
  endtask

  task automatic test_flush();
    set_req(0, 20'h0);
    set_req(1, 20'h0);
    flush = 1'b1;
    settle();
    chk_ready("flush_ready", 2'b00);
    checks++;
    if (conflict !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_outputs: conflict=%b wb_valid=%b required 0 0", conflict, wb_valid);
    end
    step();
    flush = 1'b0;
    settle();
    chk_ready("flush_ptr_held", 2'b10);
    step();
    idle();
    flush = 1'b1;
    settle();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after_grant: got %b required 0", wb_valid);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_reset_midstream();
    set_req(0, 20'h0);
    set_req(1, 20'h0);
    settle();
    chk_ready("midrst_grant", 2'b01);
    step();
    reset = 1'b1;
    settle();
    chk_ready("midrst_ready", 2'b00);
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_wb_valid: got %b required 0", wb_valid);
    end
    step();
    reset = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: got %b required 0", wb_valid);
    end
    chk_ready("midrst_first_grant", 2'b01);
    exp_q.push_back(make_exp(0, 20'h0));
    step();
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 3; c++) begin
      set_req(1, 20'h0);
      settle();
      chk_ready("b2b_single", 2'b10);
      exp_q.push_back(make_exp(1, 20'h0));
      step();
    end
    set_req(0, 20'h0);
    set_req(1, 20'h0);
    settle();
    chk_ready("b2b_ptr_past", 2'b01);
    exp_q.push_back(make_exp(0, 20'h0));
    step();
    idle();
    step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bm = '0; rob = '0; pdst = '0; rtype = '0; data = '0; ffv = '0; ffl = '0;
    #1;
    test_reset();
    test_alternate();
    test_mispredict();
    test_resolve_kill();
    test_resolve_on_grant();
    test_flush();
    test_reset_midstream();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
